// File: rtl/free_tag_list_pkg.sv
// rtl/free_tag_list_pkg.sv - shared rename/ROB tag constants and tag type
package free_tag_list_pkg;

    localparam int NUM_TAGS  = 64;
    localparam int ARCH_REGS = 32;
    localparam int TAG_W     = $clog2(NUM_TAGS);
    localparam int NULL_TAG  = 0;

    typedef logic [TAG_W-1:0] tag_t;

endpackage

// File: rtl/free_tag_list_if.sv
// rtl/free_tag_list_if.sv - ROB freed-tag and rename allocation bundle for the free list
interface free_tag_list_if
    import free_tag_list_pkg::*;
#(
    parameter int TAG_BITS   = TAG_W,
    parameter int COUNT_BITS = $clog2(NUM_TAGS - ARCH_REGS) + 1
);

    logic [TAG_BITS-1:0]   freed_tag_1;
    logic [TAG_BITS-1:0]   freed_tag_2;
    logic                  alloc_enable;
    logic [TAG_BITS-1:0]   alloc_tag;
    logic                  alloc_available;
    logic [COUNT_BITS-1:0] free_count;

    modport master (
        output freed_tag_1, freed_tag_2, alloc_enable,
        input  alloc_tag, alloc_available, free_count
    );

    modport slave (
        input  freed_tag_1, freed_tag_2, alloc_enable,
        output alloc_tag, alloc_available, free_count
    );

endinterface

// File: rtl/free_tag_bitmap.sv
// rtl/free_tag_bitmap.sv - per-tag "is free" bitmap used when FREE_TAG_LIST_CHECK_EN is defined
module free_tag_bitmap
    import free_tag_list_pkg::*;
#(
    parameter int TAGS     = NUM_TAGS,
    parameter int ARCH     = ARCH_REGS,
    parameter int TAG_BITS = $clog2(TAGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [TAG_BITS-1:0] tag_1,
    input  logic [TAG_BITS-1:0] tag_2,
    input  logic                set_1,
    input  logic                set_2,
    input  logic                clr_en,
    input  logic [TAG_BITS-1:0] clr_tag,
    output logic                accept_1,
    output logic                accept_2
);

    logic [TAGS-1:0] is_free;

    // A tag may be freed only if it is a real tag and not already sitting in the free list.
    assign accept_1 = (32'(tag_1) < TAGS) && !is_free[tag_1];
    assign accept_2 = (32'(tag_2) < TAGS) && !is_free[tag_2];

    // Allocation clears the popped tag; accepted frees mark their tags free again.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TAGS; i++) begin
                is_free[i] <= (i >= ARCH);
            end
        end else begin
            if (clr_en) is_free[clr_tag] <= 1'b0;
            if (set_1)  is_free[tag_1]   <= 1'b1;
            if (set_2)  is_free[tag_2]   <= 1'b1;
        end
    end

endmodule

// File: rtl/free_tag_list.sv
// rtl/free_tag_list.sv - physical-register free list; FREE_TAG_LIST_CHECK_EN adds double-free checking
module free_tag_list #(
    parameter int NUM_TAGS  = free_tag_list_pkg::NUM_TAGS,
    parameter int ARCH_REGS = free_tag_list_pkg::ARCH_REGS
) (
    input  logic           clk,
    input  logic           reset,
`ifdef FREE_TAG_LIST_CHECK_EN
    output logic           free_error,
`endif
    free_tag_list_if.slave bus
);
    import free_tag_list_pkg::*;

    localparam int DEPTH    = NUM_TAGS - ARCH_REGS;
    localparam int TAG_BITS = $clog2(NUM_TAGS);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef logic [TAG_BITS-1:0] slot_t;

    slot_t            mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic             nonzero_1;
    logic             nonzero_2;
    logic             valid_1;
    logic             valid_2;
    logic             pop;
    logic             push_1;
    logic             push_2;
    logic [CNT_W:0]   space;

    assign bus.alloc_available = (count != '0);
    assign bus.alloc_tag       = bus.alloc_available ? mem[head] : '0;
    assign bus.free_count      = count;

    assign nonzero_1 = (bus.freed_tag_1 != TAG_BITS'(NULL_TAG));
    assign nonzero_2 = (bus.freed_tag_2 != TAG_BITS'(NULL_TAG));

    // An allocation against an empty list is ignored; a same-cycle free is not bypassed.
    assign pop = bus.alloc_enable && bus.alloc_available;

`ifdef FREE_TAG_LIST_CHECK_EN
    logic accept_1;
    logic accept_2;
    logic dup_pair;
    logic err_event;

    free_tag_bitmap #(
        .TAGS     (NUM_TAGS),
        .ARCH     (ARCH_REGS),
        .TAG_BITS (TAG_BITS)
    ) u_bitmap (
        .clk      (clk),
        .reset    (reset),
        .tag_1    (bus.freed_tag_1),
        .tag_2    (bus.freed_tag_2),
        .set_1    (push_1),
        .set_2    (push_2),
        .clr_en   (pop),
        .clr_tag  (bus.alloc_tag),
        .accept_1 (accept_1),
        .accept_2 (accept_2)
    );

    // The same tag on both retire slots is queued once, via slot 1.
    assign dup_pair  = nonzero_1 && nonzero_2 && (bus.freed_tag_1 == bus.freed_tag_2);
    assign valid_1   = nonzero_1 && accept_1;
    assign valid_2   = nonzero_2 && accept_2 && !dup_pair;
    assign err_event = (nonzero_1 && !accept_1) || (nonzero_2 && (!accept_2 || dup_pair));

    // Sticky record of any illegal free since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_error <= 1'b0;
        end else if (err_event) begin
            free_error <= 1'b1;
        end
    end
`else
    assign valid_1 = nonzero_1;
    assign valid_2 = nonzero_2;
`endif

    // Free slots after this cycle's pop; slot 2 is the first push to be dropped on overflow.
    assign space  = (CNT_W + 1)'(DEPTH) - {1'b0, count} + {{CNT_W{1'b0}}, pop};
    assign push_1 = valid_1 && (space != '0);
    assign push_2 = valid_2 && (space > {{CNT_W{1'b0}}, push_1});

    // Circular queue: reset image holds the non-architectural tags in ascending order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_BITS'(ARCH_REGS + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
        end else begin
            if (push_1) mem[tail] <= bus.freed_tag_1;
            if (push_2) mem[tail + PTR_W'(push_1)] <= bus.freed_tag_2;
            if (pop)    head <= head + PTR_W'(1);
            tail  <= tail + PTR_W'(push_1) + PTR_W'(push_2);
            count <= count + CNT_W'(push_1) + CNT_W'(push_2) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_free_tag_list.sv
// tb/tb_free_tag_list.sv - scoreboard bench for free_tag_list (FREE_TAG_LIST_CHECK_EN optional)
module tb_free_tag_list;
    import free_tag_list_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    free_tag_list_if bus ();

`ifdef FREE_TAG_LIST_CHECK_EN
    logic free_error;
`endif

    free_tag_list dut (
        .clk        (clk),
        .reset      (reset),
`ifdef FREE_TAG_LIST_CHECK_EN
        .free_error (free_error),
`endif
        .bus        (bus)
    );

    int   checks = 0;
    int   errors = 0;
    tag_t exp_q[$];
    bit   mon_en = 1'b0;
    int   next_tag = 8;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard pop: an accepted allocation removes the expected head at the sampling edge.
    always @(posedge clk) begin
        if (mon_en && !reset && bus.alloc_enable && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    end

    // Monitor: away from the edge, compare presented outputs against the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_available", int'(bus.alloc_available), int'(exp_q.size() != 0));
            chk("mon_count", int'(bus.free_count), exp_q.size());
            if (exp_q.size() != 0) chk("mon_tag", int'(bus.alloc_tag), int'(exp_q[0]));
            else                   chk("mon_tag_empty", int'(bus.alloc_tag), 0);
        end
    end

    // One clock of stimulus; e1/e2 are the tags expected to be queued (0 = none).
    task automatic cycle(input int f1, input int f2, input bit en, input bit rst,
                         input int e1, input int e2);
        bus.freed_tag_1  = tag_t'(f1);
        bus.freed_tag_2  = tag_t'(f2);
        bus.alloc_enable = en;
        reset            = rst;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            for (int i = 32; i < 64; i++) exp_q.push_back(tag_t'(i));
        end else begin
            if (e1 != 0) exp_q.push_back(tag_t'(e1));
            if (e2 != 0) exp_q.push_back(tag_t'(e2));
        end
        bus.freed_tag_1  = '0;
        bus.freed_tag_2  = '0;
        bus.alloc_enable = 1'b0;
        reset            = 1'b0;
    endtask

    task automatic look(input string name, input int tag, input int avail, input int cnt);
        @(negedge clk);
        #1;
        chk({name, "_tag"},   int'(bus.alloc_tag),       tag);
        chk({name, "_avail"}, int'(bus.alloc_available), avail);
        chk({name, "_count"}, int'(bus.free_count),      cnt);
    endtask

    function automatic int take_tag();
        int t;
        t = next_tag;
        next_tag = (next_tag == 63) ? 8 : next_tag + 1;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        bus.freed_tag_1  = '0;
        bus.freed_tag_2  = '0;
        bus.alloc_enable = 1'b0;

        cycle(0, 0, 0, 1, 0, 0);
        mon_en = 1'b1;
        look("reset", 32, 1, 32);

        for (int i = 0; i < 32; i++) cycle(0, 0, 1, 0, 0, 0);
        look("drained", 0, 0, 0);

        cycle(0, 0, 1, 0, 0, 0);
        look("empty_alloc", 0, 0, 0);

        cycle(1, 2, 1, 0, 1, 2);
        look("no_bypass", 1, 1, 2);
        cycle(0, 0, 1, 0, 0, 0);
        look("second", 2, 1, 1);
        cycle(0, 0, 1, 0, 0, 0);
        look("empty_again", 0, 0, 0);

        cycle(0, 5, 0, 0, 0, 5);
        look("slot2_only", 5, 1, 1);
        cycle(0, 0, 0, 0, 0, 0);
        look("idle", 5, 1, 1);
        cycle(0, 0, 1, 0, 0, 0);

        cycle(7, 0, 0, 0, 7, 0);
        look("head7", 7, 1, 1);
        cycle(3, 4, 1, 0, 3, 4);
        look("pop_push", 3, 1, 2);

        for (int i = 0; i < 48; i++) begin
            case (i % 3)
                0: begin
                    a = take_tag();
                    b = take_tag();
                    cycle(a, b, 1, 0, a, b);
                end
                1: begin
                    b = take_tag();
                    cycle(0, b, 1, 0, 0, b);
                end
                default: cycle(0, 0, 1, 0, 0, 0);
            endcase
        end
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle(0, 0, 1, 0, 0, 0);
        look("wrap_drained", 0, 0, 0);

        cycle(11, 12, 0, 0, 11, 12);
        cycle(13, 14, 0, 0, 13, 14);
        cycle(15, 0, 0, 0, 15, 0);
        look("pre_reset", 11, 1, 5);
        cycle(20, 21, 1, 1, 0, 0);
        look("mid_reset", 32, 1, 32);

`ifdef FREE_TAG_LIST_CHECK_EN
        chk("err_after_reset", int'(free_error), 0);
        cycle(40, 0, 0, 0, 0, 0);
        look("double_free", 32, 1, 32);
        chk("err_double_free", int'(free_error), 1);
        cycle(0, 0, 0, 0, 0, 0);
        chk("err_sticky", int'(free_error), 1);

        cycle(0, 0, 0, 1, 0, 0);
        chk("err_cleared", int'(free_error), 0);
        cycle(0, 0, 1, 0, 0, 0);
        look("popped_one", 33, 1, 31);
        cycle(9, 9, 0, 0, 9, 0);
        look("dup_pair", 33, 1, 32);
        chk("err_dup_pair", int'(free_error), 1);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) cycle(0, 0, 1, 0, 0, 0);
        look("dup_drained", 0, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
